// File: rtl/input_port_unit.sv
// Router input port: circular flit FIFO, per-packet route latch, valid/ready
// hand-off to the switch stage. Stray non-head flits are dropped in IDLE.
package input_port_unit_pkg;
    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } inout_Port;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_t;
endpackage

module input_port_unit #(
    parameter int BUFFER_SIZE     = 8,
    parameter int FLIT_SIZE       = 32,
    parameter int x_Des_Addr_Size = 2,
    parameter int y_Des_Addr_Size = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FLIT_SIZE-1:0]             data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic [x_Des_Addr_Size-1:0]       x_Dest,
    output logic [y_Des_Addr_Size-1:0]       y_Dest,
    input  input_port_unit_pkg::inout_Port   port_i,
    output logic [FLIT_SIZE-1:0]             data_o,
    output logic                             valid_o,
    output input_port_unit_pkg::inout_Port   port_o,
    input  logic                             ready_i,
    output logic                             error_o
);
    import input_port_unit_pkg::*;

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t               state, state_next;
    logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [FLIT_SIZE-1:0] front;
    flit_type_t           front_type;
    logic                 empty, push, pop, drop, latch_route, front_is_last;

    assign empty         = (count == '0);
    assign ready_o       = (count != CNT_W'(BUFFER_SIZE));
    assign front         = mem[rd_ptr];
    assign front_type    = flit_type_t'(front[FLIT_SIZE-1 -: 2]);
    assign front_is_last = (front_type == TAIL) || (front_type == HEADTAIL);
    assign x_Dest        = empty ? '0 : front[FLIT_SIZE-3 -: x_Des_Addr_Size];
    assign y_Dest        = empty ? '0 : front[FLIT_SIZE-3-x_Des_Addr_Size -: y_Des_Addr_Size];
    assign data_o        = valid_o ? front : '0;
    assign push          = valid_i && ready_o;
    assign pop           = (valid_o && ready_i) || drop;

    // Flit storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    // FIFO pointers and occupancy; reset flushes everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // State register, latched route and registered drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            port_o  <= LOCAL;
            error_o <= 1'b0;
        end else begin
            state   <= state_next;
            error_o <= drop;
            if (latch_route) port_o <= port_i;
        end
    end

    // Next state, routing/drop decisions and switch-side valid
    always_comb begin
        state_next  = state;
        valid_o     = 1'b0;
        drop        = 1'b0;
        latch_route = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if ((front_type == HEAD) || (front_type == HEADTAIL)) begin
                        latch_route = 1'b1;
                        state_next  = ACTIVE;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                valid_o = !empty;
                if (valid_o && ready_i && front_is_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_input_port_unit.sv
// Scoreboarded bench for input_port_unit: directed packets, route model
// driven from x_Dest/y_Dest, monitor checks every offered flit.
`timescale 1ns/1ps
module tb_input_port_unit;
    import input_port_unit_pkg::*;

    localparam int FS = 32;

    typedef struct {
        logic [FS-1:0] flit;
        inout_Port     port;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [FS-1:0] data_i;
    logic          valid_i;
    logic          ready_o;
    logic [1:0]    x_Dest;
    logic [1:0]    y_Dest;
    inout_Port     port_i;
    logic [FS-1:0] data_o;
    logic          valid_o;
    inout_Port     port_o;
    logic          ready_i;
    logic          error_o;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_seen = 0;
    int   exp_err  = 0;
    logic [7:0] vhist;

    input_port_unit #(
        .BUFFER_SIZE(8),
        .FLIT_SIZE(FS),
        .x_Des_Addr_Size(2),
        .y_Des_Addr_Size(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_i(data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .x_Dest(x_Dest),
        .y_Dest(y_Dest),
        .port_i(port_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .port_o(port_o),
        .ready_i(ready_i),
        .error_o(error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route computation model: fixed table on the front flit's destination
    function automatic inout_Port route(input logic [1:0] x, input logic [1:0] y);
        case ({x, y})
            4'b1001: return EAST;
            4'b0011: return SOUTH;
            4'b0100: return WEST;
            4'b1111: return NORTH;
            4'b0101: return SOUTH;
            default: return LOCAL;
        endcase
    endfunction

    always_comb port_i = route(x_Dest, y_Dest);

    function automatic logic [FS-1:0] mk(input logic [1:0] t, input logic [1:0] x,
                                         input logic [1:0] y, input logic [25:0] pl);
        return {t, x, y, pl};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [FS-1:0] f, input bit keep, input inout_Port p);
        exp_t e;
        data_i  = f;
        valid_i = 1'b1;
        for (int i = 0; i < 50 && !ready_o; i++) tick();
        if (!ready_o) check("send_ready_timeout", {63'd0, ready_o}, 64'd1);
        e.flit = f;
        e.port = p;
        if (keep) sb.push_back(e);
        tick();
        valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        ready_i = 1'b1;
        for (int i = 0; i < 100 && sb.size() > 0; i++) tick();
        check(name, sb.size(), 0);
        tick();
        ready_i = 1'b0;
    endtask

    // Monitor: every offered flit must match the scoreboard head
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got data %0h port %0d, expected no flit", data_o, port_o);
                end else begin
                    check("sb_data", data_o, sb[0].flit);
                    check("sb_port", port_o, sb[0].port);
                    if (ready_i) void'(sb.pop_front());
                end
            end else begin
                check("idle_data_zero", data_o, 0);
            end
        end
    end

    // Count cycles with error_o high
    always @(negedge clk) begin
        if (!rst && error_o) err_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        data_i  = '0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        #2;
        check("rst_ready_o", ready_o, 1);
        check("rst_valid_o", valid_o, 0);
        check("rst_data_o", data_o, 0);
        check("rst_port_o", port_o, LOCAL);
        check("rst_x_dest", x_Dest, 0);
        check("rst_y_dest", y_Dest, 0);
        check("rst_error_o", error_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // HEADTAIL x=2 y=1 routed EAST: valid two edges after acceptance
        ready_i = 1'b1;
        send(mk(2'b11, 2'd2, 2'd1, 26'h0000A1), 1'b1, EAST);
        check("ht_valid_after_e0", valid_o, 0);
        check("ht_x_dest", x_Dest, 2);
        check("ht_y_dest", y_Dest, 1);
        tick();
        check("ht_valid_after_e1", valid_o, 1);
        check("ht_port_after_e1", port_o, EAST);
        tick();
        check("ht_valid_after_e2", valid_o, 0);
        check("ht_ready_after_e2", ready_o, 1);
        check("ht_empty_x_dest", x_Dest, 0);
        ready_i = 1'b0;
        tick();

        // 4-flit packet to SOUTH with ready_i toggling; body flits route LOCAL
        send(mk(2'b00, 2'd0, 2'd3, 26'h0000B0), 1'b1, SOUTH);
        send(mk(2'b01, 2'd0, 2'd0, 26'h0000B1), 1'b1, SOUTH);
        send(mk(2'b01, 2'd0, 2'd0, 26'h0000B2), 1'b1, SOUTH);
        send(mk(2'b10, 2'd0, 2'd0, 26'h0000B3), 1'b1, SOUTH);
        check("pkt4_port_latched", port_o, SOUTH);
        ready_i = 1'b0;
        for (int i = 0; i < 40 && sb.size() > 0; i++) begin
            ready_i = ~ready_i;
            tick();
        end
        check("pkt4_drained", sb.size(), 0);
        tick();
        ready_i = 1'b0;
        tick();

        // Fill to 8 with ready_i=0, reject a 9th, then one pop frees a slot
        send(mk(2'b00, 2'd1, 2'd0, 26'h0000C0), 1'b1, WEST);
        for (int i = 1; i <= 6; i++)
            send(mk(2'b01, 2'd0, 2'd0, 26'h0000C0 + 26'(i)), 1'b1, WEST);
        send(mk(2'b10, 2'd0, 2'd0, 26'h0000C7), 1'b1, WEST);
        check("full_ready_o", ready_o, 0);
        data_i  = mk(2'b01, 2'd0, 2'd0, 26'h000999);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        check("full_9th_ready_o", ready_o, 0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("after_pop_ready_o", ready_o, 1);
        drain("full_drained");
        tick();

        // Back-to-back packets WEST then NORTH: one bubble between them
        ready_i = 1'b1;
        send(mk(2'b00, 2'd1, 2'd0, 26'h0000D0), 1'b1, WEST);
        vhist[0] = valid_o;
        send(mk(2'b01, 2'd0, 2'd0, 26'h0000D1), 1'b1, WEST);
        vhist[1] = valid_o;
        send(mk(2'b10, 2'd0, 2'd0, 26'h0000D2), 1'b1, WEST);
        vhist[2] = valid_o;
        send(mk(2'b00, 2'd3, 2'd3, 26'h0000E0), 1'b1, NORTH);
        vhist[3] = valid_o;
        send(mk(2'b10, 2'd0, 2'd0, 26'h0000E1), 1'b1, NORTH);
        vhist[4] = valid_o;
        check("b2b_port_in_bubble", port_o, WEST);
        tick();
        vhist[5] = valid_o;
        check("b2b_port_second", port_o, NORTH);
        tick();
        vhist[6] = valid_o;
        tick();
        vhist[7] = valid_o;
        check("b2b_valid_pattern", vhist, 8'h6E);
        ready_i = 1'b0;
        tick();

        // Stray BODY in IDLE: dropped with a single error pulse
        send(mk(2'b01, 2'd3, 2'd2, 26'h000BAD), 1'b0, LOCAL);
        exp_err++;
        check("drop_error_after_e0", error_o, 0);
        check("drop_x_dest_after_e0", x_Dest, 3);
        tick();
        check("drop_error_after_e1", error_o, 1);
        check("drop_empty_x_dest", x_Dest, 0);
        check("drop_ready_o", ready_o, 1);
        tick();
        check("drop_error_after_e2", error_o, 0);
        tick();

        // Reset mid-packet after two of four flits consumed
        send(mk(2'b00, 2'd1, 2'd1, 26'h0000F0), 1'b1, SOUTH);
        send(mk(2'b01, 2'd0, 2'd0, 26'h0000F1), 1'b1, SOUTH);
        send(mk(2'b01, 2'd0, 2'd0, 26'h0000F2), 1'b1, SOUTH);
        send(mk(2'b10, 2'd0, 2'd0, 26'h0000F3), 1'b1, SOUTH);
        ready_i = 1'b1;
        tick();
        tick();
        ready_i = 1'b0;
        check("midrst_two_left", sb.size(), 2);
        sb.delete();
        rst = 1'b1;
        #1;
        check("midrst_ready_o", ready_o, 1);
        check("midrst_valid_o", valid_o, 0);
        check("midrst_port_o", port_o, LOCAL);
        check("midrst_data_o", data_o, 0);
        tick();
        rst = 1'b0;
        tick();
        ready_i = 1'b1;
        send(mk(2'b11, 2'd2, 2'd1, 26'h0000A2), 1'b1, EAST);
        drain("post_rst_drained");
        check("post_rst_valid_o", valid_o, 0);
        tick();

        check("error_pulses", err_seen, exp_err);
        check("sb_empty_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
